// File: rtl/pipeline_pkg.sv
// Shared pipeline-wide constants for the core and its memory-side blocks.
package pipeline;

  localparam int unsigned XLEN = 32;

endpackage

// File: rtl/c2c_w_store_buffer.sv
// Store buffer: acks core stores into a FIFO and drains them to the cache write port.
// Optional write coalescing into the newest non-head entry: define C2C_W_STORE_BUFFER_COALESCE_EN.
module c2c_w_store_buffer
  import pipeline::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_we,
  input  logic [XLEN/8-1:0] core_sel,
  input  logic [XLEN-1:0]   core_addr,
  input  logic [XLEN-1:0]   core_data,
  output logic              core_ack,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_sel,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_data,
  input  logic              mem_ack,
  output logic              empty
);

  localparam int unsigned NB  = XLEN / 8;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned LSB = $clog2(NB);

  logic [NB-1:0]   sel_q  [DEPTH];
  logic [XLEN-1:0] addr_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          full;
  logic          merge;
  logic          push;
  logic          pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == CW'(0));

`ifdef C2C_W_STORE_BUFFER_COALESCE_EN
  // Newest entry is only mergeable while it is not the head on mem_*.
  logic [PW-1:0] last;
  assign last     = tail - PW'(1);
  assign merge    = core_we && reset_n && (count >= CW'(2)) &&
                    (core_addr[XLEN-1:LSB] == addr_q[last][XLEN-1:LSB]);
  assign core_ack = core_we && reset_n && (merge || !full);
`else
  assign merge    = 1'b0;
  assign core_ack = core_we && reset_n && !full;
`endif

  assign push = core_ack && !merge;
  assign pop  = mem_we && mem_ack;

  assign mem_we   = !empty;
  assign mem_sel  = sel_q[head];
  assign mem_addr = addr_q[head];
  assign mem_data = data_q[head];

  // Pointer and occupancy tracking; a reset drops everything pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Entry storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      sel_q[tail]  <= core_sel;
      addr_q[tail] <= core_addr;
      data_q[tail] <= core_data;
    end
`ifdef C2C_W_STORE_BUFFER_COALESCE_EN
    else if (merge) begin
      sel_q[last] <= sel_q[last] | core_sel;
      for (int i = 0; i < int'(NB); i++) begin
        if (core_sel[i]) data_q[last][8*i +: 8] <= core_data[8*i +: 8];
      end
    end
`endif
  end

endmodule

// File: tb/tb_c2c_w_store_buffer.sv
// Directed bench for c2c_w_store_buffer (DEPTH=4, XLEN=32).
module tb_c2c_w_store_buffer;

  logic        clk;
  logic        reset_n;
  logic        core_we;
  logic [3:0]  core_sel;
  logic [31:0] core_addr;
  logic [31:0] core_data;
  logic        core_ack;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic        empty;

  int n_tests;
  int n_fail;

  c2c_w_store_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .core_we   (core_we),
    .core_sel  (core_sel),
    .core_addr (core_addr),
    .core_data (core_data),
    .core_ack  (core_ack),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ack   (mem_ack),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a store for one cycle and expect it to be accepted.
  task automatic store(input string tag, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
    @(negedge clk);
    core_we   = 1'b1;
    core_addr = a;
    core_sel  = s;
    core_data = d;
    #1 check(tag, 64'(core_ack), 64'd1);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset_n   = 1'b1;
    core_we   = 1'b0;
    core_sel  = '0;
    core_addr = '0;
    core_data = '0;
    mem_ack   = 1'b0;

    // Reset state, with a request pending to show core_ack is gated.
    #1 reset_n = 1'b0;
    core_we = 1'b1;
    #1;
    check("rst_core_ack", 64'(core_ack), 64'd0);
    check("rst_mem_we",   64'(mem_we),   64'd0);
    check("rst_empty",    64'(empty),    64'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    core_we = 1'b0;

    // Single store with a constant-ack cache.
    mem_ack = 1'b1;
    store("single_ack", 32'h100, 4'b1111, 32'hDEADBEEF);
    check("single_empty_before", 64'(empty), 64'd1);
    @(negedge clk);
    core_we = 1'b0;
    #1;
    check("single_mem_we",   64'(mem_we),   64'd1);
    check("single_mem_addr", 64'(mem_addr), 64'h100);
    check("single_mem_sel",  64'(mem_sel),  64'hF);
    check("single_mem_data", 64'(mem_data), 64'hDEADBEEF);
    @(negedge clk);
    #1;
    check("single_empty_after", 64'(empty),  64'd1);
    check("single_we_after",    64'(mem_we), 64'd0);

    // Fill to full with a stalled cache; fifth store must wait.
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      core_we   = 1'b1;
      core_addr = 32'(4 * i);
      core_sel  = 4'b1111;
      core_data = 32'(i);
      #1 check($sformatf("fill_ack%0d", i), 64'(core_ack), (i < 4) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    check("full_ack_during_pop", 64'(core_ack), 64'd0);
    check("drain_addr0",         64'(mem_addr), 64'h0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1 check("ack_after_free", 64'(core_ack), 64'd1);
    @(negedge clk);
    core_we = 1'b0;
    mem_ack = 1'b1;
    for (int k = 1; k < 5; k++) begin
      if (k > 1) @(negedge clk);
      #1 check($sformatf("drain_addr%0d", k), 64'(mem_addr), 64'(4 * k));
    end
    @(negedge clk);
    #1 check("fill_empty_end", 64'(empty), 64'd1);

    // Simultaneous push/pop at count 2; pointers wrap several times.
    mem_ack = 1'b0;
    store("pp_pre0", 32'h1000, 4'b1111, 32'd0);
    store("pp_pre1", 32'h1004, 4'b1111, 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      core_we   = 1'b1;
      core_addr = 32'h1000 + 32'(4 * (c + 2));
      core_data = 32'(c + 2);
      mem_ack   = 1'b1;
      #1;
      check($sformatf("pp_ack%0d", c),  64'(core_ack), 64'd1);
      check($sformatf("pp_addr%0d", c), 64'(mem_addr), 64'h1000 + 64'(4 * c));
      check($sformatf("pp_data%0d", c), 64'(mem_data), 64'(c));
    end
    @(negedge clk);
    core_we = 1'b0;
    #1 check("pp_tail_addr10", 64'(mem_addr), 64'h1028);
    @(negedge clk);
    #1 check("pp_tail_addr11", 64'(mem_addr), 64'h102C);
    @(negedge clk);
    #1 check("pp_empty_end", 64'(empty), 64'd1);

    // Stalled cache: head must hold steady until acked.
    mem_ack = 1'b0;
    store("stall_ack", 32'h200, 4'b1111, 32'h11223344);
    @(negedge clk);
    core_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("stall_addr%0d", k), 64'(mem_addr), 64'h200);
      check($sformatf("stall_data%0d", k), 64'(mem_data), 64'h11223344);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    #1 check("stall_drained", 64'(empty), 64'd1);

    // Reset in the middle of a handshake with three entries pending.
    mem_ack = 1'b0;
    store("rm_st0", 32'h500, 4'b1111, 32'h5);
    store("rm_st1", 32'h504, 4'b1111, 32'h6);
    store("rm_st2", 32'h508, 4'b1111, 32'h7);
    @(negedge clk);
    core_addr = 32'h50C;
    #1;
    check("rm_pre_ack", 64'(core_ack), 64'd1);
    check("rm_pre_we",  64'(mem_we),   64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("rm_mem_we",   64'(mem_we),   64'd0);
    check("rm_core_ack", 64'(core_ack), 64'd0);
    check("rm_empty",    64'(empty),    64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    core_we = 1'b0;
    store("rm_new", 32'h300, 4'b1111, 32'h33);
    @(negedge clk);
    core_we = 1'b0;
    #1;
    check("rm_first_we",   64'(mem_we),   64'd1);
    check("rm_first_addr", 64'(mem_addr), 64'h300);
    mem_ack = 1'b1;
    @(negedge clk);
    #1 check("rm_empty_end", 64'(empty), 64'd1);

    // Coalescing pattern; the expected drain sequence depends on the build.
    mem_ack = 1'b0;
    store("co_st0", 32'h40, 4'b0001, 32'h000000AA);
    store("co_st1", 32'h80, 4'b0001, 32'h00000011);
    store("co_st2", 32'h82, 4'b0100, 32'h00220000);
    @(negedge clk);
    core_we = 1'b0;
    mem_ack = 1'b1;
    #1;
    check("co_e0_addr", 64'(mem_addr), 64'h40);
    check("co_e0_sel",  64'(mem_sel),  64'h1);
    check("co_e0_data", 64'(mem_data), 64'hAA);
    @(negedge clk);
    #1;
    check("co_e1_addr", 64'(mem_addr), 64'h80);
`ifdef C2C_W_STORE_BUFFER_COALESCE_EN
    check("co_e1_sel",  64'(mem_sel),  64'h5);
    check("co_e1_data", 64'(mem_data), 64'h00220011);
    @(negedge clk);
    #1 check("co_empty_after2", 64'(empty), 64'd1);
`else
    check("co_e1_sel",  64'(mem_sel),  64'h1);
    check("co_e1_data", 64'(mem_data), 64'h11);
    @(negedge clk);
    #1;
    check("co_e2_addr", 64'(mem_addr), 64'h82);
    check("co_e2_sel",  64'(mem_sel),  64'h4);
    check("co_e2_data", 64'(mem_data), 64'h00220000);
    @(negedge clk);
    #1 check("co_empty_after3", 64'(empty), 64'd1);
`endif
    mem_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
